spi_master: RTL and testbench

- SPI initiator that drives the SPI memory slave's sclk/cs/mosi pins and samples miso.
- One command performs a single-byte read or write. The host side is a start/busy/done handshake; the pin side is SPI mode 0, MSB first.
- Frame layout:
  - Command byte = {addr[6:0], rw}.
  - Then READ_DELAY dummy bits, on reads only.
  - Then one data byte.
- Used by board-level test logic to exercise the memory over real pins.

---
 rtl/spi_master.sv | 153 +++++++++++++++
 tb/tb_spi_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one-byte read or write per start, MSB first.
// Frame = {addr[6:0], rw}, READ_DELAY dummy bits on reads only, then one data byte.
module spi_master #(
  parameter int unsigned CLKDIV     = 4,
  parameter int unsigned READ_DELAY = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int unsigned DW       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned RD_LAST  = 15 + READ_DELAY;
  localparam int unsigned BW       = $clog2(RD_LAST + 1);
  localparam int unsigned RX_FIRST = 8 + READ_DELAY;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   div_q;
  logic [BW-1:0]   bit_q;
  logic [14:0]     tx_q;
  logic [7:0]      rx_q;
  logic            rw_q;
  logic            gap_q;
  logic            sclk_q;
  logic            cs_q;
  logic            mosi_q;
  logic            busy_q;
  logic            done_q;
  logic [7:0]      rdata_q;

  logic            tick_d;
  logic [BW-1:0]   last_bit_d;

  // Divider terminal count and the frame's final bit index.
  always_comb begin
    tick_d     = (state_q != S_IDLE) && (div_q == DW'(CLKDIV - 1));
    last_bit_d = rw_q ? BW'(RD_LAST) : BW'(15);
  end

  // Frame sequencer; addr[6] goes straight to mosi, the other 15 bits shift out of tx_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rw_q    <= 1'b0;
      gap_q   <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        div_q <= '0;
      end else begin
        div_q <= tick_d ? '0 : div_q + DW'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tx_q    <= {addr[5:0], rw, wdata};
            rw_q    <= rw;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            mosi_q  <= addr[6];
            bit_q   <= '0;
            gap_q   <= 1'b0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tick_d) begin
            sclk_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (tick_d) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              if (rw_q && (bit_q >= BW'(RX_FIRST))) begin
                rx_q <= {rx_q[6:0], miso_pin};
              end
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == last_bit_d) begin
                mosi_q  <= 1'b0;
                state_q <= S_HOLD;
              end else begin
                bit_q  <= bit_q + BW'(1);
                tx_q   <= {tx_q[13:0], 1'b0};
                // Reads send zeros once past the command byte (dummy and data bits).
                mosi_q <= (rw_q && (bit_q >= BW'(7))) ? 1'b0 : tx_q[14];
              end
            end
          end
        end
        S_HOLD: begin
          if (tick_d) begin
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
            if (rw_q) begin
              rdata_q <= rx_q;
            end
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (tick_d) begin
            if (gap_q) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              gap_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign sclk_pin = sclk_q;
  assign cs_pin   = cs_q;
  assign mosi_pin = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: dut0 with READ_DELAY=0, dut1 with READ_DELAY=1,
// sharing one mode-0 slave model selected by sel.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       miso = 1'b0;

  logic       busy0, done0, sclk0, cs0, mosi0;
  logic       busy1, done1, sclk1, cs1, mosi1;
  logic [7:0] rdata0, rdata1;

  always #5 clk = ~clk;

  spi_master #(.CLKDIV(4), .READ_DELAY(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy0), .done(done0), .rdata(rdata0), .sclk_pin(sclk0), .cs_pin(cs0),
    .mosi_pin(mosi0), .miso_pin(miso)
  );

  spi_master #(.CLKDIV(4), .READ_DELAY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .rdata(rdata1), .sclk_pin(sclk1), .cs_pin(cs1),
    .mosi_pin(mosi1), .miso_pin(miso)
  );

  logic sel = 1'b0;
  logic sclk_m, cs_m, mosi_m, done_m, busy_m;
  logic [7:0] rdata_m;
  assign sclk_m  = sel ? sclk1  : sclk0;
  assign cs_m    = sel ? cs1    : cs0;
  assign mosi_m  = sel ? mosi1  : mosi0;
  assign done_m  = sel ? done1  : done0;
  assign busy_m  = sel ? busy1  : busy0;
  assign rdata_m = sel ? rdata1 : rdata0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: captures mosi on sclk rise, drives the response byte on sclk fall.
  logic [7:0]  resp = '0;
  int          rd_m = 0;
  int          pulses = 0;
  logic [31:0] mosi_word = '0;

  always @(negedge cs_m) begin
    pulses    = 0;
    mosi_word = '0;
    miso      = 1'b0;
  end

  always @(posedge sclk_m) begin
    mosi_word = {mosi_word[30:0], mosi_m};
    pulses++;
  end

  always @(negedge sclk_m) begin
    if (cs_m === 1'b0) begin
      if (pulses >= 8 + rd_m && pulses <= 15 + rd_m) miso = resp[15 + rd_m - pulses];
      else miso = 1'b0;
    end
  end

  // Pin-rule monitors across all frames.
  int   done_cnt0 = 0;
  int   mosi_viol = 0;
  int   idle_viol = 0;
  int   done_viol = 0;
  logic pm = 1'b0, ps = 1'b0, pd = 1'b0;

  always @(posedge done0) done_cnt0++;

  always @(negedge clk) begin
    if (!reset) begin
      if (mosi_m !== pm && sclk_m && ps) mosi_viol++;
      if (cs_m && sclk_m) idle_viol++;
      if (done_m && pd) done_viol++;
    end
    pm = mosi_m;
    ps = sclk_m;
    pd = done_m;
  end

  task automatic run_frame(input logic which, input logic r, input logic [6:0] a,
                           input logic [7:0] d, input logic [7:0] rsp, output int unsigned t0);
    @(negedge clk);
    sel   = which;
    rw    = r;
    addr  = a;
    wdata = d;
    resp  = rsp;
    rd_m  = which ? 1 : 0;
    if (which) start1 = 1'b1;
    else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done_m) break;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      if (!busy_m) break;
      @(negedge clk);
    end
  endtask

  int unsigned t0;
  int          dc;
  int          gap;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_cs",    32'(cs0),    32'h1);
    check_eq("rst_sclk",  32'(sclk0),  32'h0);
    check_eq("rst_mosi",  32'(mosi0),  32'h0);
    check_eq("rst_busy",  32'(busy0),  32'h0);
    check_eq("rst_done",  32'(done0),  32'h0);
    check_eq("rst_rdata", 32'(rdata0), 32'h0);
    reset = 1'b0;

    // Read addr 0x15, slave returns 0xC3.
    run_frame(1'b0, 1'b1, 7'h15, 8'h00, 8'hC3, t0);
    wait_done();
    check_eq("rd_done_lat", cyc - t0, 32'd132);
    check_eq("rd_cs_at_done", 32'(cs_m), 32'h1);
    check_eq("rd_rdata", 32'(rdata_m), 32'hC3);
    check_eq("rd_pulses", 32'(pulses), 32'd16);
    check_eq("rd_mosi", mosi_word, 32'h2B00);
    wait_idle();
    check_eq("rd_busy_lat", cyc - t0, 32'd140);

    // Write addr 0x15, data 0xA5.
    run_frame(1'b0, 1'b0, 7'h15, 8'hA5, 8'h00, t0);
    wait_done();
    check_eq("wr_done_lat", cyc - t0, 32'd132);
    check_eq("wr_cs_at_done", 32'(cs_m), 32'h1);
    check_eq("wr_pulses", 32'(pulses), 32'd16);
    check_eq("wr_mosi", mosi_word, 32'h2AA5);
    check_eq("wr_rdata_kept", 32'(rdata_m), 32'hC3);
    wait_idle();
    check_eq("wr_busy_lat", cyc - t0, 32'd140);

    // Reset in the middle of bit 5 of a write.
    run_frame(1'b0, 1'b0, 7'h15, 8'hA5, 8'h00, t0);
    repeat (46) @(negedge clk);
    dc = done_cnt0;
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_cs",   32'(cs0),   32'h1);
    check_eq("mid_rst_sclk", 32'(sclk0), 32'h0);
    check_eq("mid_rst_mosi", 32'(mosi0), 32'h0);
    check_eq("mid_rst_busy", 32'(busy0), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check_eq("mid_rst_no_done", 32'(done_cnt0 - dc), 32'd0);

    // Reset together with start.
    reset  = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    check_eq("rst_start_busy", 32'(busy0), 32'h0);
    reset  = 1'b0;
    start0 = 1'b0;
    @(negedge clk);

    // Start pulse and operand change while busy are ignored.
    dc = done_cnt0;
    run_frame(1'b0, 1'b0, 7'h33, 8'h5C, 8'h00, t0);
    repeat (9) @(negedge clk);
    addr   = 7'h7F;
    wdata  = 8'hFF;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done();
    check_eq("hs_mosi", mosi_word, 32'h665C);
    check_eq("hs_pulses", 32'(pulses), 32'd16);
    wait_idle();
    repeat (20) @(negedge clk);
    check_eq("hs_one_frame", 32'(done_cnt0 - dc), 32'd1);

    // start held high: two back-to-back frames separated by the full gap.
    dc = done_cnt0;
    @(negedge clk);
    sel    = 1'b0;
    rw     = 1'b0;
    addr   = 7'h01;
    wdata  = 8'h81;
    start0 = 1'b1;
    wait_done();
    check_eq("b2b_mosi1", mosi_word, 32'h0281);
    gap = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cs_m) gap++;
      else break;
    end
    check_eq("b2b_cs_gap", 32'(gap), 32'd9);
    start0 = 1'b0;
    wait_done();
    check_eq("b2b_mosi2", mosi_word, 32'h0281);
    wait_idle();
    repeat (20) @(negedge clk);
    check_eq("b2b_two_frames", 32'(done_cnt0 - dc), 32'd2);

    // READ_DELAY=1 read, slave returns 0x5A after one dummy bit.
    run_frame(1'b1, 1'b1, 7'h15, 8'h00, 8'h5A, t0);
    wait_done();
    check_eq("rd1_done_lat", cyc - t0, 32'd140);
    check_eq("rd1_rdata", 32'(rdata_m), 32'h5A);
    check_eq("rd1_pulses", 32'(pulses), 32'd17);
    check_eq("rd1_mosi", mosi_word, 32'h5600);
    wait_idle();
    check_eq("rd1_busy_lat", cyc - t0, 32'd148);

    repeat (5) @(negedge clk);
    #1;
    check_eq("mosi_stable_sclk_hi", 32'(mosi_viol), 32'd0);
    check_eq("sclk_low_cs_high", 32'(idle_viol), 32'd0);
    check_eq("done_one_clk", 32'(done_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
